// File: rtl/fpu_pkg.sv
// Shared FPU types: register address/data widths and the writeback result pair.
package fpu_pkg;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] NO_WB_ADDR = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fpu_result_t;
endpackage

// File: rtl/fpu_wb_queue_if.sv
// FPU writeback queue bus: result input, register-file write port and forwarding lookups.
interface fpu_wb_queue_if import fpu_pkg::*; #(parameter int DEPTH = 4);
    logic                     in_valid;
    logic                     in_ready;
    logic [ADDR_W-1:0]        in_addr;
    logic [DATA_W-1:0]        in_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_grant;
    logic [ADDR_W-1:0]        fwd_addr_a;
    logic                     fwd_hit_a;
    logic [DATA_W-1:0]        fwd_data_a;
    logic [ADDR_W-1:0]        fwd_addr_b;
    logic                     fwd_hit_b;
    logic [DATA_W-1:0]        fwd_data_b;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_addr, in_data, wr_grant, fwd_addr_a, fwd_addr_b,
        input  in_ready, wr_en, wr_addr, wr_data, fwd_hit_a, fwd_data_a,
               fwd_hit_b, fwd_data_b, count
    );

    modport slave (
        input  in_valid, in_addr, in_data, wr_grant, fwd_addr_a, fwd_addr_b,
        output in_ready, wr_en, wr_addr, wr_data, fwd_hit_a, fwd_data_a,
               fwd_hit_b, fwd_data_b, count
    );
endinterface

// File: rtl/fpu_fwd_lookup.sv
// Youngest-first search of the queued results for one operand address.
module fpu_fwd_lookup import fpu_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]        i_vld,
    input  fpu_result_t [DEPTH-1:0] i_ent,
    input  logic [PW-1:0]           i_head,
    input  logic [ADDR_W-1:0]       i_addr,
    output logic                    o_hit,
    output logic [DATA_W-1:0]       o_data
);
    logic [PW-1:0] w_idx;

    // Walk oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PW'(k);
            if (i_vld[w_idx] && (i_ent[w_idx].addr == i_addr) && (i_addr != NO_WB_ADDR)) begin
                o_hit  = 1'b1;
                o_data = i_ent[w_idx].data;
            end
        end
    end
endmodule

// File: rtl/fpu_wb_queue.sv
// In-order FIFO between the FPU and the shared register-file write port,
// with two combinational forwarding lookups over pending results.
module fpu_wb_queue import fpu_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fpu_wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

    logic [DEPTH-1:0]        r_vld;
    fpu_result_t [DEPTH-1:0] r_ent;
    logic [PW-1:0]           r_head;
    logic [PW-1:0]           r_tail;
    logic [PW:0]             r_count;

    logic w_in_ready;
    logic w_wr_en;
    logic w_push;
    logic w_pop;

    // Ready depends only on registered occupancy: a full queue never takes a
    // result in the same cycle a grant frees a slot.
    assign w_in_ready = !rst && (r_count != CNT_FULL);
    assign w_wr_en    = r_vld[r_head];
    assign w_push     = bus.in_valid && w_in_ready && (bus.in_addr != NO_WB_ADDR);
    assign w_pop      = w_wr_en && bus.wr_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by r_vld alone.
    always_ff @(posedge clk) begin
        if (w_push) r_ent[r_tail] <= '{addr: bus.in_addr, data: bus.in_data};
    end

    assign bus.in_ready = w_in_ready;
    assign bus.wr_en    = w_wr_en;
    assign bus.wr_addr  = r_ent[r_head].addr;
    assign bus.wr_data  = r_ent[r_head].data;
    assign bus.count    = r_count;

    fpu_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_a (
        .i_vld  (r_vld),
        .i_ent  (r_ent),
        .i_head (r_head),
        .i_addr (bus.fwd_addr_a),
        .o_hit  (bus.fwd_hit_a),
        .o_data (bus.fwd_data_a)
    );

    fpu_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_b (
        .i_vld  (r_vld),
        .i_ent  (r_ent),
        .i_head (r_head),
        .i_addr (bus.fwd_addr_b),
        .o_hit  (bus.fwd_hit_b),
        .o_data (bus.fwd_data_b)
    );
endmodule

// File: tb/tb_fpu_wb_queue.sv
// Scoreboard bench for fpu_wb_queue: a reference queue is checked every cycle.
module tb_fpu_wb_queue;
    import fpu_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;

    fpu_result_t exp_q[$];

    fpu_wb_queue_if #(.DEPTH(DEPTH)) bus ();

    fpu_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus; inputs change 1 time unit after the edge.
    task automatic step(input bit v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit g, input logic [ADDR_W-1:0] fa, input logic [ADDR_W-1:0] fb);
        bus.in_valid   = v;
        bus.in_addr    = a;
        bus.in_data    = d;
        bus.wr_grant   = g;
        bus.fwd_addr_a = fa;
        bus.fwd_addr_b = fb;
        @(posedge clk);
        #1;
    endtask

    task automatic fwd_model(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != NO_WB_ADDR)
            foreach (exp_q[i])
                if (exp_q[i].addr == a) begin
                    hit = 1'b1;
                    d   = exp_q[i].data;
                end
    endtask

    // Compare at the falling edge against the model, then advance the model
    // by what the next rising edge will do.
    always @(negedge clk) begin
        logic               e_rdy, e_wen, h;
        logic [DATA_W-1:0]  fd;
        if (mon_on) begin
            e_rdy = !rst && (exp_q.size() < DEPTH);
            e_wen = exp_q.size() != 0;
            chk("in_ready", 32'(bus.in_ready), 32'(e_rdy));
            chk("wr_en",    32'(bus.wr_en),    32'(e_wen));
            chk("count",    32'(bus.count),    32'(exp_q.size()));
            if (e_wen) begin
                chk("wr_addr", 32'(bus.wr_addr), 32'(exp_q[0].addr));
                chk("wr_data", bus.wr_data, exp_q[0].data);
            end
            fwd_model(bus.fwd_addr_a, h, fd);
            chk("fwd_hit_a",  32'(bus.fwd_hit_a), 32'(h));
            chk("fwd_data_a", bus.fwd_data_a, fd);
            fwd_model(bus.fwd_addr_b, h, fd);
            chk("fwd_hit_b",  32'(bus.fwd_hit_b), 32'(h));
            chk("fwd_data_b", bus.fwd_data_b, fd);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (e_wen && bus.wr_grant) void'(exp_q.pop_front());
                if (bus.in_valid && e_rdy && bus.in_addr != NO_WB_ADDR)
                    exp_q.push_back('{addr: bus.in_addr, data: bus.in_data});
            end
        end
    end

    initial begin
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        mon_on = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // single result with grant held high
        step(1, 6'd5, 32'h3F800000, 1, 6'd5, 0);
        step(0, 0, 0, 1, 6'd5, 0);
        step(0, 0, 0, 1, 6'd5, 0);

        // zero-address result is consumed and dropped
        step(1, 6'd0, 32'hDEADBEEF, 1, 6'd0, 6'd0);
        step(0, 0, 0, 1, 6'd0, 0);
        step(0, 0, 0, 1, 0, 0);

        // fill, backpressure, then drain in order
        for (int i = 1; i <= 4; i++) step(1, 6'(i), 32'h1000 + i, 0, 6'd2, 6'd4);
        step(1, 6'd9, 32'h9999, 0, 6'd9, 0);
        step(0, 0, 0, 0, 6'd1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 6'd3, 6'd4);

        // youngest-match forwarding, survives popping the older copy
        step(1, 6'd7, 32'h40000000, 0, 6'd7, 6'd8);
        step(1, 6'd7, 32'h40400000, 0, 6'd7, 6'd8);
        step(0, 0, 0, 0, 6'd7, 6'd8);
        step(0, 0, 0, 1, 6'd7, 6'd8);
        step(0, 0, 0, 0, 6'd7, 6'd8);
        step(0, 0, 0, 1, 6'd7, 6'd8);
        step(0, 0, 0, 1, 6'd7, 6'd8);

        // streaming push/pop every cycle wraps both pointers
        for (int i = 0; i < 10; i++) step(1, 6'(10 + i), 32'hA000 + i, 1, 6'(10 + i), 6'(9 + i));
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // reset with entries pending discards them
        for (int i = 0; i < 3; i++) step(1, 6'(20 + i), 32'hB000 + i, 0, 6'd21, 6'd22);
        rst = 1'b1;
        step(0, 0, 0, 0, 6'd21, 6'd22);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 6'd21, 6'd22);

        // random traffic with small address range to provoke aliasing
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 1), 6'($urandom_range(0, 6)), $urandom,
                 $urandom_range(0, 1), 6'($urandom_range(0, 6)), 6'($urandom_range(0, 6)));
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0);

        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_wb_queue.md
Name: fpu_wb_queue

Overview:
Writeback queue directly downstream of the FPU datapath. It captures each (reg_addr, dd_val) result pair in a small in-order FIFO and drains it through the register-file write port, which is shared with the integer side and granted by an external arbiter. While results wait for a grant, two combinational forwarding ports expose pending values to operand fetch, and a pending flag per lookup supports hazard checks.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
ADDR_W, 6, register address width; matches FPU reg_addr
DATA_W, 32, result width; matches FPU dd_val

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  FPU result valid this cycle
in_ready  out  1  queue can accept a result
in_addr  in  ADDR_W  FPU reg_addr; 0 = no writeback
in_data  in  DATA_W  FPU dd_val
wr_en  out  1  write request to register file (head entry valid)
wr_addr  out  ADDR_W  head entry address
wr_data  out  DATA_W  head entry data
wr_grant  in  1  arbiter accepts head this cycle
fwd_addr_a  in  ADDR_W  lookup address A
fwd_hit_a  out  1  A matches a queued entry
fwd_data_a  out  DATA_W  data of youngest matching entry for A, else 0
fwd_addr_b  in  ADDR_W  lookup address B
fwd_hit_b  out  1  B matches a queued entry
fwd_data_b  out  DATA_W  data of youngest matching entry for B, else 0
count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset: head/tail pointers, count, and all entry valid bits go to 0. While `rst` is high, `in_ready` = 0. `wr_en` = 0 and `fwd_hit_*` = 0 from the first edge with `rst` sampled high. Entry data is not reset.
- Reset mid-operation: all queued entries are discarded with no write issued.
- `in_ready` = !rst && (count < DEPTH). It is registered-state based: no same-cycle pass-through when full, even if `wr_grant` = 1.
- Accept: occurs when in_valid && in_ready.
  - If in_addr != 0, enqueue at the tail; the tail pointer increments modulo DEPTH.
  - If in_addr == 0, the result is consumed and dropped; no entry is written and count is unchanged.
- Drain:
  - `wr_en` = head entry valid; `wr_addr`/`wr_data` come straight from head storage.
  - wr_grant && wr_en pops the head; the head pointer increments modulo DEPTH.
  - `wr_grant` while `wr_en` = 0 is ignored.
- Latency: a result accepted in cycle N is presented on `wr_en` in cycle N+1 at the earliest, when the queue was empty.
- Hold rule: `wr_addr`/`wr_data` are stable while wr_en && !wr_grant.
- Simultaneous accept and pop: count is unchanged; both pointers advance.
- Ordering: strictly in-order. Multiple entries with the same address are permitted; the register file receives them in order.
- Forwarding:
  - Purely combinational over the currently valid entries only. The same-cycle `in_*` input is not searched.
  - Priority goes to the youngest (closest to tail) matching entry.
  - A lookup address of 0 never hits.
  - The head entry being popped in this cycle still hits.
- Count width: holds 0..DEPTH inclusive.

Decomposition:
- Shared package fpu_pkg: ADDR_W, DATA_W, NO_WB_ADDR = 0, and a struct/typedef fpu_result_t {addr, data}. The FPU and this queue both use this package.
- One sub-module: fpu_fwd_lookup.
  - Parameterized by DEPTH.
  - Inputs: entry valid/addr/data vectors, head pointer, and lookup address.
  - Outputs: hit and data via youngest-first priority search.
  - Instantiated twice, for ports A and B.

Test Plan:
- Reset then single result: in_addr=5, in_data=0x3F800000, wr_grant=1 → wr_en=1, wr_addr=5, wr_data=0x3F800000 next cycle; count 1→0; then wr_en=0.
- Zero-address drop: in_valid with in_addr=0, data=0xDEADBEEF → in_ready=1, count stays 0, wr_en never asserts, fwd_hit_a=0 for fwd_addr_a=0.
- Fill and backpressure: wr_grant=0, push addresses 1,2,3,4 → count=4, in_ready=0. A 5th push (addr 9) is not accepted. Raise wr_grant → writes appear in order 1,2,3,4 on consecutive cycles; in_ready returns 1 the cycle after the first pop.
- Forward youngest: wr_grant=0, push (7,0x40000000) then (7,0x40400000) → fwd_addr_a=7 gives hit=1, data=0x40400000. fwd_addr_b=8 gives hit=0, data=0. Pop once → A still 0x40400000.
- Simultaneous push/pop with pointer wrap: run 10 results through with wr_grant=1 every cycle and in_valid every cycle → count stays 1, pointers wrap, outputs match input order with one-cycle latency.
- Reset mid-operation: 3 entries queued, assert rst for one cycle → next cycle count=0, wr_en=0, fwd hits 0; after deassert in_ready=1 and no stale write ever issued.
